// File: rtl/rifl_axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat with per-lane keep.
// Partial words are flushed on input tlast or after TIMEOUT idle cycles.
module rifl_axis_upsizer #(
  parameter int DWIDTH  = 32,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DWIDTH-1:0]       s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DWIDTH*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]        m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int LCW = $clog2(RATIO);
  localparam int WW  = DWIDTH * RATIO;

  logic [WW-1:0]    acc_data;
  logic [LCW-1:0]   lane_cnt;
  logic             out_free;
  logic             s_accept;
  logic             completing;
  logic             flush;
  logic             load_out;
  logic [WW-1:0]    word_next;
  logic [RATIO-1:0] keep_next;

  assign out_free      = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = out_free;
  assign s_accept      = s_axis_tvalid & out_free;
  assign completing    = s_accept & (s_axis_tlast | (lane_cnt == LCW'(RATIO - 1)));
  assign load_out      = completing | flush;

  // Unused accumulator lanes are always zero, so the outgoing word needs no masking.
  always_comb begin
    word_next = acc_data;
    keep_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (s_accept && (LCW'(i) == lane_cnt)) begin
        word_next[i*DWIDTH +: DWIDTH] = s_axis_tdata;
      end
      keep_next[i] = completing ? (LCW'(i) <= lane_cnt) : (LCW'(i) < lane_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data <= '0;
      lane_cnt <= '0;
    end else if (load_out) begin
      acc_data <= '0;
      lane_cnt <= '0;
    end else if (s_accept) begin
      acc_data <= word_next;
      lane_cnt <= lane_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load_out) begin
      m_axis_tdata  <= word_next;
      m_axis_tkeep  <= keep_next;
      m_axis_tlast  <= completing & s_axis_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [TW-1:0] idle_cnt;
      logic          idle_done;

      assign idle_done = (idle_cnt == TW'(TIMEOUT - 1));
      // Saturates at the terminal count so a blocked output flushes the moment it frees.
      assign flush     = idle_done & (lane_cnt != '0) & ~s_accept & out_free;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          idle_cnt <= '0;
        end else if (s_accept || (lane_cnt == '0) || flush) begin
          idle_cnt <= '0;
        end else if (!idle_done) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign flush = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_rifl_axis_upsizer.sv
// Bench for rifl_axis_upsizer: directed packing/timeout/backpressure/reset cases,
// then a random stream checked against a queue-based packing model.
module tb_rifl_axis_upsizer;

  localparam int DW = 32;
  localparam int RT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [127:0]  m_tdata;
  logic [RT-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;

  int n_tests = 0;
  int n_fail  = 0;

  rifl_axis_upsizer #(.DWIDTH(DW), .RATIO(RT), .TIMEOUT(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    tick();
  endtask

  // Reference model: accepted narrow beats queued in order, packed into wide words.
  logic [32:0]  in_q[$];
  logic         mon_en = 1'b0;
  logic         hold_v = 1'b0;
  logic [127:0] hold_d;
  int           n_out = 0;
  logic [127:0] mon_d;
  logic [RT-1:0] mon_k;
  logic         mon_l;
  int           mon_n;
  logic [32:0]  mon_b;

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_v && m_tvalid) chk("rnd_stable", m_tdata, hold_d);
      if (m_tvalid && m_tready) begin
        mon_d = '0;
        mon_k = '0;
        mon_l = 1'b0;
        mon_n = 0;
        while (mon_n < RT && !mon_l && in_q.size() > 0) begin
          mon_b = in_q.pop_front();
          mon_d[mon_n*DW +: DW] = mon_b[31:0];
          mon_k[mon_n] = 1'b1;
          mon_l = mon_b[32];
          mon_n++;
        end
        chk("rnd_data", m_tdata, mon_d);
        chk("rnd_keep", 128'(m_tkeep), 128'(mon_k));
        chk("rnd_last", 128'(m_tlast), 128'(mon_l));
        n_out++;
      end
      hold_v = m_tvalid & ~m_tready;
      hold_d = m_tdata;
      if (s_tvalid && s_tready) in_q.push_back({s_tlast, s_tdata});
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int k;
    int seen;
    int sent;
    int cyc;
    logic acc;
    logic [127:0] held;

    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 128'(m_tvalid), 128'(0));
    chk("rst_last", 128'(m_tlast), 128'(0));
    chk("rst_keep", 128'(m_tkeep), 128'(0));
    chk("rst_data", m_tdata, 128'(0));
    rst_n = 1'b1;
    tick();

    // 8 beats, full throughput, tlast on beat 8
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'(i + 1); s_tlast = (i == 7);
      @(negedge clk);
      chk("t1_sready", 128'(s_tready), 128'(1));
      tick();
      chk("t1_mvalid", 128'(m_tvalid), 128'(i == 3 || i == 7));
      if (i == 3) begin
        chk("t1_w0_data", m_tdata, pack4(32'h1, 32'h2, 32'h3, 32'h4));
        chk("t1_w0_keep", 128'(m_tkeep), 128'(4'hF));
        chk("t1_w0_last", 128'(m_tlast), 128'(0));
      end
      if (i == 7) begin
        chk("t1_w1_data", m_tdata, pack4(32'h5, 32'h6, 32'h7, 32'h8));
        chk("t1_w1_keep", 128'(m_tkeep), 128'(4'hF));
        chk("t1_w1_last", 128'(m_tlast), 128'(1));
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();

    // short packet, then a tlast beat alone in lane 0
    send_beat(32'hA, 1'b0);
    send_beat(32'hB, 1'b0);
    send_beat(32'hC, 1'b1);
    chk("t2_valid", 128'(m_tvalid), 128'(1));
    chk("t2_data", m_tdata, pack4(32'hA, 32'hB, 32'hC, 32'h0));
    chk("t2_keep", 128'(m_tkeep), 128'(4'h7));
    chk("t2_last", 128'(m_tlast), 128'(1));
    send_beat(32'hD, 1'b1);
    chk("t2_lane0_data", m_tdata, pack4(32'hD, 32'h0, 32'h0, 32'h0));
    chk("t2_lane0_keep", 128'(m_tkeep), 128'(4'h1));
    chk("t2_lane0_last", 128'(m_tlast), 128'(1));
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();

    // idle timeout, output ready
    send_beat(32'h11, 1'b0);
    send_beat(32'h22, 1'b0);
    s_tvalid = 1'b0;
    k = 0;
    while (!m_tvalid && k < 200) begin tick(); k++; end
    chk("t3_flush_delay", 128'(k), 128'(64));
    chk("t3_data", m_tdata, pack4(32'h11, 32'h22, 32'h0, 32'h0));
    chk("t3_keep", 128'(m_tkeep), 128'(4'h3));
    chk("t3_last", 128'(m_tlast), 128'(0));
    tick();

    // idle timeout with the sink stalled: flushed word waits for tready
    m_tready = 1'b0;
    send_beat(32'h33, 1'b0);
    send_beat(32'h44, 1'b0);
    s_tvalid = 1'b0;
    k = 0;
    while (!m_tvalid && k < 200) begin tick(); k++; end
    chk("t3b_flush_delay", 128'(k), 128'(64));
    repeat (8) tick();
    chk("t3b_held_valid", 128'(m_tvalid), 128'(1));
    chk("t3b_held_data", m_tdata, pack4(32'h33, 32'h44, 32'h0, 32'h0));
    chk("t3b_held_keep", 128'(m_tkeep), 128'(4'h3));
    m_tready = 1'b1;
    tick();
    chk("t3b_drained", 128'(m_tvalid), 128'(0));

    // backpressure: full word held, 5th beat taken on the draining cycle
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(32'(i), 1'b0);
    chk("t4_valid", 128'(m_tvalid), 128'(1));
    chk("t4_data", m_tdata, pack4(32'h1, 32'h2, 32'h3, 32'h4));
    held = m_tdata;
    s_tvalid = 1'b1; s_tdata = 32'h5; s_tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_sready_low", 128'(s_tready), 128'(0));
      tick();
      chk("t4_data_stable", m_tdata, held);
      chk("t4_keep_stable", 128'(m_tkeep), 128'(4'hF));
    end
    m_tready = 1'b1;
    @(negedge clk);
    chk("t4_sready_rise", 128'(s_tready), 128'(1));
    tick();
    chk("t4_consumed", 128'(m_tvalid), 128'(0));
    send_beat(32'h6, 1'b0);
    send_beat(32'h7, 1'b0);
    send_beat(32'h8, 1'b1);
    chk("t4_w1_data", m_tdata, pack4(32'h5, 32'h6, 32'h7, 32'h8));
    chk("t4_w1_keep", 128'(m_tkeep), 128'(4'hF));
    chk("t4_w1_last", 128'(m_tlast), 128'(1));
    s_tvalid = 1'b0; s_tlast = 1'b0;
    tick();

    // async reset mid-word
    send_beat(32'h51, 1'b0);
    send_beat(32'h52, 1'b0);
    s_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("t5_mid_word_valid", 128'(m_tvalid), 128'(0));
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin tick(); if (m_tvalid) seen++; end
    chk("t5_no_spurious", 128'(seen), 128'(0));
    for (int i = 1; i <= 4; i++) send_beat(32'h60 + 32'(i), 1'b0);
    s_tvalid = 1'b0;
    chk("t5_clean_data", m_tdata, pack4(32'h61, 32'h62, 32'h63, 32'h64));
    chk("t5_clean_keep", 128'(m_tkeep), 128'(4'hF));
    tick();

    // async reset while a word is held
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(32'h70 + 32'(i), i == 4);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("t5_hold_valid", 128'(m_tvalid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(m_tvalid), 128'(0));
    chk("t5_rst_last", 128'(m_tlast), 128'(0));
    chk("t5_rst_keep", 128'(m_tkeep), 128'(0));
    chk("t5_rst_data", m_tdata, 128'(0));
    tick();
    rst_n = 1'b1;
    m_tready = 1'b1;
    tick();
    chk("t5_post_idle", 128'(m_tvalid), 128'(0));
    for (int i = 1; i <= 4; i++) send_beat(32'h80 + 32'(i), 1'b0);
    s_tvalid = 1'b0;
    chk("t5_post_data", m_tdata, pack4(32'h81, 32'h82, 32'h83, 32'h84));
    chk("t5_post_keep", 128'(m_tkeep), 128'(4'hF));
    tick();
    tick();

    // random stream against the packing model
    mon_en = 1'b1;
    sent = 0;
    cyc = 0;
    s_tvalid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!s_tvalid && $urandom_range(0, 1) == 1) begin
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        s_tlast  = (sent == 9999) || ($urandom_range(0, 7) == 0);
      end
      m_tready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = s_tvalid & s_tready;
      tick();
      if (acc) begin
        sent++;
        s_tvalid = 1'b0;
      end
      cyc++;
    end
    chk("rnd_budget", 128'(sent), 128'(10000));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (5) tick();
    mon_en = 1'b0;
    chk("rnd_drain", 128'(in_q.size()), 128'(0));
    chk("rnd_words_seen", 128'(n_out > 1000), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
